// File: rtl/riscv_imem_sequencer_pkg.sv
// Shared types and constants for the instruction-memory sequencer.
package riscv_imem_sequencer_pkg;

   localparam int unsigned UPG_ADDR_W  = 14;
   localparam int unsigned XLEN        = 32;
   localparam int unsigned LOAD_CNT_W  = UPG_ADDR_W + 1;
   localparam int unsigned HOLD_CNT_W  = 8;
   localparam logic [XLEN-1:0] IMEM_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IMEM_SEQ_RUN     = 2'd0,
      IMEM_SEQ_LOAD    = 2'd1,
      IMEM_SEQ_RELEASE = 2'd2
   } imem_seq_state_e;

   // One access on the RAM port
   typedef struct packed {
      logic                  en;
      logic                  we;
      logic [UPG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       wdata;
   } imem_port_t;

endpackage

// File: rtl/riscv_imem_sequencer_if.sv
// Bundles the programmer, fetch and RAM-port signals around the sequencer.
interface riscv_imem_sequencer_if;
   import riscv_imem_sequencer_pkg::*;

   logic                  upg_rst_i;
   logic                  upg_wen_i;
   logic [UPG_ADDR_W-1:0] upg_adr_i;
   logic [XLEN-1:0]       upg_dat_i;
   logic                  upg_done_i;
   logic                  if_req;
   logic [XLEN-1:0]       if_addr;
   logic [XLEN-1:0]       if_inst;
   logic                  if_valid;
   logic                  if_fault;
   logic                  mem_en;
   logic                  mem_we;
   logic [UPG_ADDR_W-1:0] mem_addr;
   logic [XLEN-1:0]       mem_wdata;
   logic [XLEN-1:0]       mem_rdata;
   logic                  cpu_hold;
   logic [LOAD_CNT_W-1:0] load_words;
   logic                  load_err;

   // master: the sequencer itself; slave: the surrounding fetch/programmer/RAM
   modport master (
      input  upg_rst_i, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
      input  if_req, if_addr, mem_rdata,
      output if_inst, if_valid, if_fault,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output cpu_hold, load_words, load_err
   );

   modport slave (
      output upg_rst_i, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
      output if_req, if_addr, mem_rdata,
      input  if_inst, if_valid, if_fault,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  cpu_hold, load_words, load_err
   );

endinterface

// File: rtl/riscv_imem_hold_timer.sv
// Loadable down-counter; done_c is high in the last counted cycle (count == 1).
module riscv_imem_hold_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   output logic             done_c
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (start) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - WIDTH'(1);
      end
   end

   assign done_c = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/riscv_imem_sequencer.sv
// Instruction RAM port owner: fetch in RUN, UART programmer in LOAD, timed core release.
// Build option RISCV_IMEM_BOOT_LOAD_EN: boot into LOAD with the core held.
module riscv_imem_sequencer
   import riscv_imem_sequencer_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 16384,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   riscv_imem_sequencer_if.master bus
);

   localparam logic [LOAD_CNT_W-1:0] LOAD_MAX   = LOAD_CNT_W'(1 << UPG_ADDR_W);
   localparam logic [LOAD_CNT_W-1:0] WR_LIMIT   = LOAD_CNT_W'(DEPTH_WORDS);
   localparam logic [XLEN-3:0]       FETCH_LIM  = (XLEN-2)'(DEPTH_WORDS);
   localparam logic [HOLD_CNT_W-1:0] HOLD_VAL   = HOLD_CNT_W'(HOLD_CYCLES);

`ifdef RISCV_IMEM_BOOT_LOAD_EN
   localparam imem_seq_state_e BOOT_STATE = IMEM_SEQ_LOAD;
   localparam logic            BOOT_HOLD  = 1'b1;
`else
   localparam imem_seq_state_e BOOT_STATE = IMEM_SEQ_RUN;
   localparam logic            BOOT_HOLD  = 1'b0;
`endif

   imem_seq_state_e       state_q, state_d;
   imem_port_t            port_c;
   logic                  fetch_go_c, fetch_ok_c, wr_ok_c;
   logic                  timer_start_c, timer_done_c;
   logic                  valid_q, fault_q, hold_q, err_q;
   logic [LOAD_CNT_W-1:0] words_q;

   // A programmer start in the same cycle preempts a fetch
   assign fetch_go_c    = (state_q == IMEM_SEQ_RUN) && bus.if_req && bus.upg_rst_i;
   assign fetch_ok_c    = (bus.if_addr[1:0] == 2'b00) && (bus.if_addr[XLEN-1:2] < FETCH_LIM);
   assign wr_ok_c       = ({1'b0, bus.upg_adr_i} < WR_LIMIT);
   assign timer_start_c = (state_q == IMEM_SEQ_LOAD) && bus.upg_done_i;

   riscv_imem_hold_timer #(.WIDTH(HOLD_CNT_W)) u_hold_timer (
      .clk      (clk),
      .rst      (rst),
      .start    (timer_start_c),
      .load_val (HOLD_VAL),
      .done_c   (timer_done_c)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= BOOT_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IMEM_SEQ_RUN: begin
            if (!bus.upg_rst_i) state_d = IMEM_SEQ_LOAD;
         end
         IMEM_SEQ_LOAD: begin
            if (bus.upg_done_i) state_d = IMEM_SEQ_RELEASE;
         end
         IMEM_SEQ_RELEASE: begin
            if (!bus.upg_rst_i && !bus.upg_done_i) state_d = IMEM_SEQ_LOAD;
            else if (timer_done_c)                 state_d = IMEM_SEQ_RUN;
         end
         default: state_d = IMEM_SEQ_RUN;
      endcase
   end

   // RAM port mux; RELEASE leaves the port idle
   always_comb begin
      port_c = '0;
      unique case (state_q)
         IMEM_SEQ_RUN: begin
            port_c.en   = fetch_go_c && fetch_ok_c;
            port_c.addr = bus.if_addr[UPG_ADDR_W+1:2];
         end
         IMEM_SEQ_LOAD: begin
            port_c.en    = bus.upg_wen_i && wr_ok_c;
            port_c.we    = bus.upg_wen_i && wr_ok_c;
            port_c.addr  = bus.upg_adr_i;
            port_c.wdata = bus.upg_dat_i;
         end
         default: port_c = '0;
      endcase
   end

   assign bus.mem_en    = port_c.en;
   assign bus.mem_we    = port_c.we;
   assign bus.mem_addr  = port_c.addr;
   assign bus.mem_wdata = port_c.wdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         fault_q <= 1'b0;
         hold_q  <= BOOT_HOLD;
      end else begin
         valid_q <= fetch_go_c;
         fault_q <= fetch_go_c && !fetch_ok_c;
         hold_q  <= (state_d != IMEM_SEQ_RUN);
      end
   end

   // Session statistics, cleared on every entry into LOAD
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         words_q <= '0;
         err_q   <= 1'b0;
      end else if ((state_q != IMEM_SEQ_LOAD) && (state_d == IMEM_SEQ_LOAD)) begin
         words_q <= '0;
         err_q   <= 1'b0;
      end else if ((state_q == IMEM_SEQ_LOAD) && bus.upg_wen_i) begin
         if (!wr_ok_c)               err_q   <= 1'b1;
         else if (words_q != LOAD_MAX) words_q <= words_q + LOAD_CNT_W'(1);
      end
   end

   assign bus.if_valid   = valid_q;
   assign bus.if_fault   = fault_q;
   assign bus.if_inst    = !valid_q ? '0 : (fault_q ? IMEM_NOP : bus.mem_rdata);
   assign bus.cpu_hold   = hold_q;
   assign bus.load_words = words_q;
   assign bus.load_err   = err_q;

endmodule
